// File: rtl/draw_cmd_arbiter.sv
// draw_cmd_arbiter
// Round-robin arbiter that shares one rectangle-draw engine between several
// command sources, with a per-frame command budget re-armed by frame_start.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              when low, no new grants are issued
//   frame_start         single-cycle pulse, re-arms the per-frame budget
//   in_valid/in_ready   per-source handshake (in_ready one-hot or zero)
//   in_x/y/w/h/color    packed per-source rectangle fields (source i at slot i)
//   out_valid/out_ready handshake towards the draw engine
//   out_x/y/w/h/color   registered command held for the engine
//   out_src             index of the source that issued the held command
//   frame_count         commands accepted since the last frame_start
//   budget_hit          high while frame_count equals MAX_PER_FRAME
module draw_cmd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PIX_WIDTH     = 32,
  parameter int MAX_PER_FRAME = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           frame_start,
  input  logic [NUM_REQ-1:0]             in_valid,
  output logic [NUM_REQ-1:0]             in_ready,
  input  logic [NUM_REQ*16-1:0]          in_x,
  input  logic [NUM_REQ*16-1:0]          in_y,
  input  logic [NUM_REQ*16-1:0]          in_w,
  input  logic [NUM_REQ*16-1:0]          in_h,
  input  logic [NUM_REQ*PIX_WIDTH-1:0]   in_color,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    out_x,
  output logic [15:0]                    out_y,
  output logic [15:0]                    out_w,
  output logic [15:0]                    out_h,
  output logic [PIX_WIDTH-1:0]           out_color,
  output logic [$clog2(NUM_REQ)-1:0]     out_src,
  output logic [7:0]                     frame_count,
  output logic                           budget_hit
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_CNT = 8'(MAX_PER_FRAME);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;
  logic [15:0]          out_x_q, out_x_d;
  logic [15:0]          out_y_q, out_y_d;
  logic [15:0]          out_w_q, out_w_d;
  logic [15:0]          out_h_q, out_h_d;
  logic [PIX_WIDTH-1:0] out_color_q, out_color_d;
  logic [7:0]           frame_count_q, frame_count_d;
  logic                 budget_hit_q, budget_hit_d;

  logic                 found;
  logic [SRC_W-1:0]     sel;
  logic [SRC_W-1:0]     cand;
  int unsigned          base;
  logic                 grant_ok;
  logic                 accept;
  logic [15:0]          x_sel, y_sel, w_sel, h_sel;
  logic [PIX_WIDTH-1:0] color_sel;

  // Round-robin scan starting just after the last granted source.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    base  = 32'(last_grant_q);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((base + 1 + k) % NUM_REQ);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // rst gates the grant so in_ready drops in the same cycle reset asserts.
  always_comb begin
    grant_ok = (state_q == ST_EMPTY) && enable && !rst &&
               ((frame_count_q < MAX_CNT) || frame_start);
    accept   = grant_ok && found;
    in_ready = accept ? (NUM_REQ'(1) << sel) : '0;
  end

  always_comb begin
    x_sel     = '0;
    y_sel     = '0;
    w_sel     = '0;
    h_sel     = '0;
    color_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (SRC_W'(i) == sel) begin
        x_sel     = in_x[16*i +: 16];
        y_sel     = in_y[16*i +: 16];
        w_sel     = in_w[16*i +: 16];
        h_sel     = in_h[16*i +: 16];
        color_sel = in_color[PIX_WIDTH*i +: PIX_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_src_d    = out_src_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_w_d      = out_w_q;
    out_h_d      = out_h_q;
    out_color_d  = out_color_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_FULL;
          last_grant_d = sel;
          out_src_d    = sel;
          out_x_d      = x_sel;
          out_y_d      = y_sel;
          out_w_d      = w_sel;
          out_h_d      = h_sel;
          out_color_d  = color_sel;
        end
      end
      ST_FULL: begin
        if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // An accept in the frame_start cycle counts towards the new frame.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start) begin
      frame_count_d = accept ? 8'd1 : 8'd0;
    end else if (accept && (frame_count_q < MAX_CNT)) begin
      frame_count_d = frame_count_q + 8'd1;
    end
    budget_hit_d = (frame_count_d == MAX_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      last_grant_q  <= SRC_W'(NUM_REQ - 1);
      out_src_q     <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_w_q       <= '0;
      out_h_q       <= '0;
      out_color_q   <= '0;
      frame_count_q <= '0;
      budget_hit_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      out_src_q     <= out_src_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_w_q       <= out_w_d;
      out_h_q       <= out_h_d;
      out_color_q   <= out_color_d;
      frame_count_q <= frame_count_d;
      budget_hit_q  <= budget_hit_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_w       = out_w_q;
  assign out_h       = out_h_q;
  assign out_color   = out_color_q;
  assign out_src     = out_src_q;
  assign frame_count = frame_count_q;
  assign budget_hit  = budget_hit_q;

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
module tb_draw_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame_start;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] in_x, in_y, in_w, in_h;
  logic [127:0] in_color;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x, out_y, out_w, out_h;
  logic [31:0] out_color;
  logic [1:0]  out_src;
  logic [7:0]  frame_count;
  logic        budget_hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  draw_cmd_arbiter #(
    .NUM_REQ      (4),
    .PIX_WIDTH    (32),
    .MAX_PER_FRAME(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_w       (in_w),
    .in_h       (in_h),
    .in_color   (in_color),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_w      (out_w),
    .out_h      (out_h),
    .out_color  (out_color),
    .out_src    (out_src),
    .frame_count(frame_count),
    .budget_hit (budget_hit)
  );

  typedef struct {
    logic       en;
    logic       fs;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_src;
    logic [7:0] e_fc;
    logic       e_bh;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en fs vld ordy | rdy ov src fc bh   (MAX_PER_FRAME=3)
    vt[0]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 8'd1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 8'd1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 8'd2, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd1, 8'd2, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 8'd3, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd3, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd3, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 1'b0, 2'd2, 8'd3, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3, 8'd1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd3, 8'd1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd2, 1'b0};
    vt[12] = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd2, 1'b0};
    vt[13] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 8'd0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0};
    vt[16] = '{1'b1, 1'b0, 4'b0101, 1'b0, 4'b0100, 1'b0, 2'd0, 8'd0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2, 8'd1, 1'b0};
    vt[18] = '{1'b0, 1'b0, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd2, 8'd1, 1'b0};
    vt[19] = '{1'b0, 1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd1, 1'b0};
    vt[20] = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd1, 1'b0};
    vt[21] = '{1'b1, 1'b0, 4'b0011, 1'b1, 4'b0001, 1'b0, 2'd2, 8'd1, 1'b0};
    vt[22] = '{1'b1, 1'b0, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd0, 8'd2, 1'b0};

    rst         = 1'b1;
    enable      = 1'b0;
    frame_start = 1'b0;
    in_valid    = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_x[16*i +: 16]     = 16'(10 + i);
      in_y[16*i +: 16]     = 16'(20 + i);
      in_w[16*i +: 16]     = 16'(30 + i);
      in_h[16*i +: 16]     = 16'(40 + i);
      in_color[32*i +: 32] = 32'hC0DE0000 + 32'(i);
    end

    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_budget_hit", 32'(budget_hit), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_out_color", out_color, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      enable      = vt[i].en;
      frame_start = vt[i].fs;
      in_valid    = vt[i].vld;
      out_ready   = vt[i].ordy;
      #3;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vt[i].e_src));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(vt[i].e_fc));
      chk($sformatf("v%0d_budget_hit", i), 32'(budget_hit), 32'(vt[i].e_bh));
      step();
    end

    // Clear the frame budget without granting anything.
    in_valid    = '0;
    enable      = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_clear_count", 32'(frame_count), 32'd0);

    // Source 2 alone, held by the engine for 10 cycles.
    in_x[32 +: 16]     = 16'd100;
    in_y[32 +: 16]     = 16'd200;
    in_w[32 +: 16]     = 16'd400;
    in_h[32 +: 16]     = 16'd400;
    in_color[64 +: 32] = 32'h00FF8000;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #2;
    chk("s2_in_ready", 32'(in_ready), 32'b0100);
    step();
    chk("s2_out_valid", 32'(out_valid), 32'd1);
    chk("s2_out_x", 32'(out_x), 32'd100);
    chk("s2_out_y", 32'(out_y), 32'd200);
    chk("s2_out_w", 32'(out_w), 32'd400);
    chk("s2_out_h", 32'(out_h), 32'd400);
    chk("s2_out_color", out_color, 32'h00FF8000);
    chk("s2_out_src", 32'(out_src), 32'd2);
    chk("s2_frame_count", 32'(frame_count), 32'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_x", 32'(out_x), 32'd100);
      chk("hold_out_color", out_color, 32'h00FF8000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = '0;
    step();
    chk("s2_drain", 32'(out_valid), 32'd0);

    // Fill the budget, then frame_start while FULL at frame_count=3.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #2;
    chk("b_grant3", 32'(in_ready), 32'b1000);
    step();
    chk("b_src3", 32'(out_src), 32'd3);
    out_ready = 1'b1;
    step();
    chk("b_grant0", 32'(in_ready), 32'b0001);
    out_ready = 1'b0;
    step();
    chk("b_fc3", 32'(frame_count), 32'd3);
    chk("b_hit", 32'(budget_hit), 32'd1);
    frame_start = 1'b1;
    #2;
    chk("b_fs_full_no_ready", 32'(in_ready), 32'd0);
    step();
    frame_start = 1'b0;
    chk("b_fs_fc0", 32'(frame_count), 32'd0);
    chk("b_fs_hit0", 32'(budget_hit), 32'd0);
    chk("b_fs_held_valid", 32'(out_valid), 32'd1);
    chk("b_fs_held_x", 32'(out_x), 32'd10);
    chk("b_fs_held_color", out_color, 32'hC0DE0000);
    chk("b_fs_held_src", 32'(out_src), 32'd0);
    out_ready = 1'b1;
    step();
    chk("b_drain", 32'(out_valid), 32'd0);
    chk("b_next_grant1", 32'(in_ready), 32'b0010);
    out_ready = 1'b0;
    step();
    chk("r_full", 32'(out_valid), 32'd1);

    // Asynchronous reset while FULL.
    rst = 1'b1;
    #1;
    chk("r_async_valid", 32'(out_valid), 32'd0);
    chk("r_async_fc", 32'(frame_count), 32'd0);
    chk("r_async_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #2;
    chk("r_first_grant", 32'(in_ready), 32'b0001);
    step();
    chk("r_first_src", 32'(out_src), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_cmd_arbiter.md
# draw_cmd_arbiter

Round-robin arbiter that shares one rectangle-draw engine (AXI write master on the DDR write port) between several command sources, e.g. an animated sprite, an overlay and a clear-screen source. It accepts rectangle commands over per-source valid/ready handshakes and holds the selected one in an output register until the engine accepts it. It also enforces a per-frame command budget that re-arms on each frame-start pulse, which is the vsync fall already resynchronised to the AXI clock.

## Interface
Parameters:
- NUM_REQ, 4, number of command sources (2..8)
- PIX_WIDTH, 32, colour width
- MAX_PER_FRAME, 8, commands accepted per frame (1..255)

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  AXI clock domain clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new grants are issued
- frame_start  in  1  single-cycle pulse, re-arms the budget
- in_valid  in  NUM_REQ  per-source command valid
- in_ready  out  NUM_REQ  per-source accept, one-hot or zero
- in_x, in_y, in_w, in_h  in  NUM_REQ×16 each  packed rectangle fields; source i uses bits [16i+15:16i]
- in_color  in  NUM_REQ×PIX_WIDTH  packed colour
- out_valid  out  1  command to the engine valid
- out_ready  in  1  engine accept (engine req_ready)
- out_x, out_y, out_w, out_h  out  16 each  registered command
- out_color  out  PIX_WIDTH  registered colour
- out_src  out  $clog2(NUM_REQ)  index of the granted source
- frame_count  out  8  commands accepted since the last frame_start
- budget_hit  out  1  high while frame_count == MAX_PER_FRAME

## Operation
- Output register states: EMPTY and FULL. Reset state is EMPTY.
- Reset values: out_valid=0, in_ready=0, all out_* fields=0, out_src=0, frame_count=0, budget_hit=0, last_grant=NUM_REQ-1. With last_grant at NUM_REQ-1, source 0 has top priority after reset.
- Grant condition: state EMPTY, enable=1, and (frame_count < MAX_PER_FRAME or frame_start=1) in the same cycle.
- Selection when the grant condition holds: the first i with in_valid[i]=1, scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
- in_ready is combinational. in_ready[sel]=1 only for the selected source; all others are 0.
- On accept:
  - capture in_*[sel] into out_*
  - set out_src=sel and last_grant=sel
  - go to FULL
  - increment frame_count
- In FULL:
  - out_valid=1
  - out_* fields are stable
  - in_ready=0
  - on out_valid & out_ready, go to EMPTY
- frame_start:
  - frame_count becomes 0
  - if an accept happens in the same cycle, frame_count becomes 1 instead
  - frame_start never disturbs a FULL command
- frame_count saturates at MAX_PER_FRAME. budget_hit is a registered compare of frame_count.
- enable dropping while FULL does not cancel the held command. It still completes normally.
- Sources with in_valid low are skipped. last_grant changes only on an accept.

## Timing
- Accept in cycle t: out_valid=1 from t+1.
- Engine acceptance (out_ready=1) in cycle u: out_valid=0 at u+1. The earliest next accept is also at u+1.
- Maximum throughput is one command per 2 cycles; a bubble is required.
- An accepted command reaches out_valid after 1 cycle.
- Source-side rule: a source must hold in_valid and its data stable until in_ready. The block samples the data only in the in_ready cycle.
- Reset is asserted asynchronously and released synchronously externally. Reset asserted mid-command drops the held command: out_valid falls immediately and nothing is replayed.

## Test plan
- Reset, then in_valid=4'b1111 and out_ready tied 1. Grant order is 0,1,2,3,0…; each source's in_ready pulses one cycle; out_src follows the same sequence with 2-cycle spacing.
- Source 2 alone is valid, holding x=100 y=200 w=400 h=400 color=0x00FF8000. Accepted at t, out_* equal these values at t+1. With out_ready held 0 for 10 cycles, out_valid and the fields are stable, and in_ready stays 0 for all sources.
- MAX_PER_FRAME=3 with all sources always valid:
  - exactly 3 accepts occur, then budget_hit=1 and frame_count=3, with no further in_ready
  - after a frame_start pulse, the next accept happens in that same cycle and frame_count=1
- frame_start while FULL with frame_count=3: frame_count becomes 0, and the held command completes on out_ready with the same field values.
- enable=0 with pending valids: no grants. Clearing enable while FULL: the held command still drains.
- Assert rst while FULL: out_valid=0, frame_count=0 and in_ready=0 in the same cycle (asynchronous). After release, source 0 wins the first grant.
